// File: rtl/ps2_kb_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and set-2 to HID decoder.
package ps2_kb_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_UP    = 8'h52;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_RIGHT = 8'h4F;

    // HID_NONE doubles as "not mapped"; no real key maps to 8'h00.
    function automatic logic [7:0] set2_to_hid(input logic [7:0] code, input logic ext);
        logic [7:0] hid;
        hid = HID_NONE;
        if (ext) begin
            case (code)
                8'h75:   hid = HID_UP;
                8'h72:   hid = HID_DOWN;
                8'h6B:   hid = HID_LEFT;
                8'h74:   hid = HID_RIGHT;
                default: hid = HID_NONE;
            endcase
        end else begin
            case (code)
                8'h1D:   hid = HID_W;
                8'h1B:   hid = HID_S;
                8'h1C:   hid = HID_A;
                8'h23:   hid = HID_D;
                8'h29:   hid = HID_SPACE;
                default: hid = HID_NONE;
            endcase
        end
        return hid;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 serial frame receiver: line synchronizers, start/data/parity/stop FSM and
// inactivity timeout. Strobes are combinational in the cycle the final edge is seen.
module ps2_frame_rx
    import ps2_kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_strobe,
    output logic       err_strobe
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fall;

    rx_state_t state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          perr_q, perr_d;
    logic [TW-1:0] tmo_q, tmo_d;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= RX_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        tmo_d       = '0;
        byte_strobe = 1'b0;
        err_strobe  = 1'b0;

        if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!data_s2) begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end
                end
                RX_DATA: begin
                    shift_d = {data_s2, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    // Odd parity: data plus parity bit must have an odd number of ones.
                    perr_d  = ~(^{data_s2, shift_q});
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    if (data_s2 && !perr_q) byte_strobe = 1'b1;
                    else                    err_strobe  = 1'b1;
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d    = RX_IDLE;
                err_strobe = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    assign data_byte = shift_q;

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard front end: turns set-2 make/break sequences into the HID code of
// the most recently pressed mapped key, with change and error pulses.
module ps2_keycode
    import ps2_kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_err;
    logic       ext_q, brk_q;
    logic [7:0] hid;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_byte  (rx_byte),
        .byte_strobe(rx_strobe),
        .err_strobe (rx_err)
    );

    assign hid = set2_to_hid(rx_byte, ext_q);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            keycode   <= HID_NONE;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= rx_err;
            if (rx_err) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (rx_strobe) begin
                if (rx_byte == PFX_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == PFX_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    // Only the last-pressed key is tracked; releasing any other key is ignored.
                    if (hid != HID_NONE) begin
                        if (!brk_q && hid != keycode) begin
                            keycode   <= hid;
                            key_valid <= 1'b1;
                        end else if (brk_q && hid == keycode) begin
                            keycode   <= HID_NONE;
                            key_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
